// File: rtl/seg_scan_n_if.sv
// Bus bundle for the multiplexed seven-segment scanner: content/control inputs
// from the host side and the digit/segment pins plus frame pulse back out.
interface seg_scan_n_if #(
  parameter int NUM_DIG = 8
);
  logic [4*NUM_DIG-1:0] data_in;
  logic [NUM_DIG-1:0]   dp_in;
  logic [NUM_DIG-1:0]   blank_in;
  logic                 load;
  logic [3:0]           bright;
  logic                 disp_en;
  logic [NUM_DIG-1:0]   DIG;
  logic [7:0]           Y;
  logic                 frame_done;

  modport master (
    output data_in, dp_in, blank_in, load, bright, disp_en,
    input  DIG, Y, frame_done
  );

  modport slave (
    input  data_in, dp_in, blank_in, load, bright, disp_en,
    output DIG, Y, frame_done
  );
endinterface

// File: rtl/seg_scan_n.sv
// Time-multiplexed hex seven-segment scanner with PWM brightness and
// double-buffered, frame-aligned content updates.
module seg_scan_n #(
  parameter int NUM_DIG    = 8,
  parameter int DIV        = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seg_scan_n_if.slave  bus
);
  localparam int SUB = DIV / 16;
  localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int IW  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [SW-1:0]      SUB_MAX = SW'(SUB - 1);
  localparam logic [IW-1:0]      IDX_MAX = IW'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] DIG_OFF = {NUM_DIG{ACTIVE_LOW}};
  localparam logic [7:0]         Y_OFF   = {8{ACTIVE_LOW}};

  // tick is held as (phase, sub) so the PWM phase needs no divider;
  // tick = phase*SUB + sub, wrapping at DIV-1 exactly when phase=15, sub=SUB-1.
  logic [SW-1:0]        sub_q, sub_d;
  logic [3:0]           phase_q, phase_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [4*NUM_DIG-1:0] pData_q, pData_d, dData_q, dData_d;
  logic [NUM_DIG-1:0]   pDp_q, pDp_d, dDp_q, dDp_d;
  logic [NUM_DIG-1:0]   pBlank_q, pBlank_d, dBlank_q, dBlank_d;
  logic                 frame_q, frame_d;
  logic [NUM_DIG-1:0]   dig_q, dig_d;
  logic [7:0]           y_q, y_d;

  logic                 slotEnd, boundary, lit;
  logic [3:0]           nib;
  logic [6:0]           seg;
  logic [NUM_DIG-1:0]   oneHot;

  always_comb begin
    sub_d    = sub_q + 1'b1;
    phase_d  = phase_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    pData_d  = pData_q;
    pDp_d    = pDp_q;
    pBlank_d = pBlank_q;
    dData_d  = dData_q;
    dDp_d    = dDp_q;
    dBlank_d = dBlank_q;
    dig_d    = DIG_OFF;
    y_d      = Y_OFF;
    seg      = 7'h00;

    slotEnd  = (phase_q == 4'hF) && (sub_q == SUB_MAX);
    boundary = slotEnd && (idx_q == IDX_MAX);
    frame_d  = boundary;

    if (sub_q == SUB_MAX) begin
      sub_d   = '0;
      phase_d = phase_q + 4'd1;
    end
    if (slotEnd) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // A load landing on the boundary itself wins over any older pending data.
    if (bus.load) begin
      pData_d  = bus.data_in;
      pDp_d    = bus.dp_in;
      pBlank_d = bus.blank_in;
      pend_d   = 1'b1;
    end
    if (boundary) begin
      if (bus.load) begin
        dData_d  = bus.data_in;
        dDp_d    = bus.dp_in;
        dBlank_d = bus.blank_in;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        dData_d  = pData_q;
        dDp_d    = pDp_q;
        dBlank_d = pBlank_q;
        pend_d   = 1'b0;
      end
    end

    nib = dData_q[4*int'(idx_q) +: 4];
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase

    oneHot = NUM_DIG'(1) << idx_q;
    lit    = (phase_q <= bus.bright) && bus.disp_en && !dBlank_q[idx_q];
    if (lit) begin
      dig_d = oneHot ^ DIG_OFF;
      y_d   = {dDp_q[idx_q], seg} ^ Y_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q    <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      pData_q  <= '0;
      pDp_q    <= '0;
      pBlank_q <= '0;
      dData_q  <= '0;
      dDp_q    <= '0;
      dBlank_q <= '0;
      frame_q  <= 1'b0;
      dig_q    <= DIG_OFF;
      y_q      <= Y_OFF;
    end else begin
      sub_q    <= sub_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pData_q  <= pData_d;
      pDp_q    <= pDp_d;
      pBlank_q <= pBlank_d;
      dData_q  <= dData_d;
      dDp_q    <= dDp_d;
      dBlank_q <= dBlank_d;
      frame_q  <= frame_d;
      dig_q    <= dig_d;
      y_q      <= y_d;
    end
  end

  assign bus.DIG        = dig_q;
  assign bus.Y          = y_q;
  assign bus.frame_done = frame_q;
endmodule

// File: doc/seg_scan_n.md
SEG_SCAN_N -- requirements
Module: seg_scan_n

Interface
REQ-001 Parameter NUM_DIG, default 8: number of digits scanned; legal range 1..8.
REQ-002 Parameter DIV, default 100000: clk cycles per digit slot; must be a multiple of 16 and at least 16.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, DIG and Y are active-low; when 0, active-high.
REQ-004 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 data_in  in  4*NUM_DIG  hex nibble per digit; nibble i drives digit i.
REQ-008 dp_in  in  NUM_DIG  decimal-point request per digit.
REQ-009 blank_in  in  NUM_DIG  per-digit blank; 1 means the digit is never lit.
REQ-010 load  in  1  one-cycle strobe that captures data_in, dp_in and blank_in.
REQ-011 bright  in  4  brightness; the digit is lit for bright+1 of 16 phases.
REQ-012 disp_en  in  1  0 forces all outputs inactive; scanning continues.
REQ-013 DIG  out  NUM_DIG  one-hot digit select; bit i selects digit i.
REQ-014 Y  out  8  segments; Y[6:0] = g..a, Y[7] = dp.
REQ-015 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-016 tick SHALL count 0..DIV-1 and then wrap to 0.
REQ-017 When tick = DIV-1, the digit index idx SHALL advance by one; after NUM_DIG-1 it SHALL wrap to 0.
REQ-018 The frame boundary is the cycle where tick = DIV-1 and idx = NUM_DIG-1; frame_done SHALL be 1 in the cycle after that cycle.
REQ-019 load SHALL copy its three inputs into a pending buffer and set the pending flag.
REQ-020 At each frame boundary, if pending is set, the pending buffer SHALL copy into the display buffer and pending SHALL clear.
REQ-021 Display content SHALL only change between frames, so no frame ever mixes old and new data.
REQ-022 load in the same cycle as a frame boundary: the new inputs SHALL go directly to the display buffer and pending SHALL end clear.
REQ-023 Back-to-back loads within one frame: only the last load SHALL be displayed.
REQ-024 Each digit slot SHALL be split into 16 phases of DIV/16 cycles; phase = tick / (DIV/16).
REQ-025 Digit idx SHALL be lit when phase <= bright, disp_en = 1 and blank for that digit = 0; otherwise DIG and Y are inactive.
REQ-026 Segment decode (gfedcba, active-high logical) SHALL be:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-027 Y[7] SHALL equal the dp bit of the selected digit, gated by the lit condition.
REQ-028 DIG and Y SHALL be registered, with one cycle of latency from tick/idx to the pins.
REQ-029 At most one DIG bit SHALL be active in any cycle.
REQ-030 Physical pin level SHALL be the logical value XOR ACTIVE_LOW, replicated across the full width.
REQ-031 Changes to bright or disp_en SHALL take effect at the pins 1 cycle later, with no frame alignment.

Reset
REQ-032 rst = 1 SHALL clear tick, idx, pending, the pending buffer and the display buffer to 0.
REQ-033 While rst = 1, frame_done SHALL be 0, and DIG and Y SHALL be inactive (all 1s when ACTIVE_LOW = 1).
REQ-034 rst asserted mid-frame SHALL discard any pending load.
REQ-035 After rst releases, scanning SHALL restart at idx 0, tick 0.
REQ-036 The first lit output SHALL appear 1 cycle after release, provided disp_en = 1 and blank = 0.

Verification
REQ-037 Common setup: NUM_DIG = 4, DIV = 32, ACTIVE_LOW = 1, bright = 15, disp_en = 1.
- Decode: load data_in = 16'h3210, dp_in = 4'b0100 -> after the next frame boundary, digit 0 shows Y = ~8'h3F.
- Decode, continued: digit 2 shows Y = ~8'hDB (dp set); DIG cycles 1110, 1101, 1011, 0111 at 32 cycles per digit.
- Tear-free update: load 16'hFFFF mid-frame -> the current frame still shows 3210; the next frame shows F = ~8'h71 on all digits; frame_done pulses every 128 cycles.
- Boundary load: load asserted exactly at tick = 31, idx = 3 -> the new data shows on digit 0 of the very next frame and pending = 0.
- Brightness: bright = 3 -> each digit is active for cycles 0..7 of its slot (plus 1 cycle latency) and inactive for the remaining 24.
- Blanking and enable: blank_in = 4'b0010 -> digit 1 is never active; disp_en = 0 -> DIG = 4'hF and Y = 8'hFF while frame_done keeps pulsing.
- Reset mid-frame: pending load, then rst for 1 cycle -> the display buffer holds 0 and digit 0 shows ~8'h3F from tick 0 with no pending update.
